captura_operandos: RTL and testbench

Parametrised operand-capture front end for the Booth multiplier. It synchronises and debounces two WIDTH-bit switch banks and the start pushbutton using one shared sample-tick divider. A button held for a programmable time fires exactly one capture. The captured operands go to the multiplier through a valid/ready handshake, and each press is latched once.

---
 rtl/captura_operandos.sv | 194 +++++++++++++++++++
 tb/tb_captura_operandos.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_operandos.sv
// Operand-capture front end for the Booth multiplier: synchronises and debounces
// two switch banks plus the start button, and hands one operand pair per press over valid/ready.
module captura_operandos #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICK_DIV       = 250000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned HOLD_TICKS     = 200
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 pb_entrada,
  input  logic                 op_ready,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  output logic                 overrun,
  output logic [2*WIDTH-1:0]   LED,
  output logic                 LED_reset,
  output logic                 LED_pb
);

  localparam int unsigned NCH    = 2*WIDTH + 1;
  localparam int unsigned TICK_W = $clog2(TICK_DIV) + 1;
  localparam int unsigned SAMP_W = $clog2(STABLE_SAMPLES) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FIRE,
    S_WAIT_RELEASE
  } state_t;

  logic [NCH-1:0]    raw_bus;
  logic [NCH-1:0]    sync_q1;
  logic [NCH-1:0]    sync_q2;
  logic [NCH-1:0]    deb_q;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              pb_deb;
  logic [WIDTH-1:0]  deb_a;
  logic [WIDTH-1:0]  deb_b;
  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              fire_c;
  logic              led_reset_q;

  // Channel order: {A, B, pb}, so LED falls straight out of the upper bits.
  assign raw_bus = {A, B, pb_entrada};
  assign pb_deb  = deb_q[0];
  assign deb_a   = deb_q[NCH-1 -: WIDTH];
  assign deb_b   = deb_q[WIDTH:1];

  // Two-flop synchroniser on every raw input
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_bus;
      sync_q2 <= sync_q1;
    end
  end

  // Shared sample-tick divider
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Symmetric per-channel debounce: STABLE_SAMPLES consecutive differing ticks flip the bit
  for (genvar ch = 0; ch < NCH; ch++) begin : g_deb
    logic [SAMP_W-1:0] samp_cnt;
    logic              deb_bit;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
        samp_cnt <= '0;
        deb_bit  <= 1'b0;
      end else if (tick) begin
        if (sync_q2[ch] != deb_bit) begin
          if (samp_cnt == SAMP_W'(STABLE_SAMPLES - 1)) begin
            deb_bit  <= sync_q2[ch];
            samp_cnt <= '0;
          end else begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end else begin
          samp_cnt <= '0;
        end
      end
    end

    assign deb_q[ch] = deb_bit;
  end

  // Start FSM state register
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Start FSM next state: one capture request per qualifying press
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    fire_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pb_deb) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (tick) begin
          if (!pb_deb) begin
            state_d = S_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_d == HOLD_W'(HOLD_TICKS)) begin
              state_d = S_FIRE;
            end
          end
        end
      end
      S_FIRE: begin
        fire_c  = 1'b1;
        state_d = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (!pb_deb) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand register and valid/ready handshake; a blocked capture raises overrun instead
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (fire_c) begin
        if (!op_valid || op_ready) begin
          op_a     <= deb_a;
          op_b     <= deb_b;
          op_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

  // Reset indicator: set asynchronously, cleared by the first clock after release
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      led_reset_q <= 1'b1;
    end else begin
      led_reset_q <= 1'b0;
    end
  end

  assign LED       = deb_q[NCH-1:1];
  assign LED_reset = led_reset_q;
  assign LED_pb    = op_valid;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: random switch/button stimulus checked cycle by cycle
// against a run-length / press-timer reference model, plus fixed scenario checks.
module tb_captura_operandos;

  localparam int W   = 8;
  localparam int TD  = 4;
  localparam int NS  = 3;
  localparam int HT  = 5;
  localparam int NCH = 2*W + 1;

  logic           clk;
  logic           reset;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           pb_entrada;
  logic           op_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_valid;
  logic           overrun;
  logic [2*W-1:0] LED;
  logic           LED_reset;
  logic           LED_pb;
  logic [35:0]    dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             m_cyc;
  logic [NCH-1:0] m_d1, m_d2, m_db;
  int             m_run [NCH];
  logic           m_last [NCH];
  logic           m_holding, m_fire, m_waitrel;
  int             m_ht;
  logic           m_valid, m_ovr, m_ledrst;
  logic [W-1:0]   m_a, m_b;

  captura_operandos #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_SAMPLES(NS), .HOLD_TICKS(HT)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .A(A), .B(B), .pb_entrada(pb_entrada),
    .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .overrun(overrun), .LED(LED), .LED_reset(LED_reset), .LED_pb(LED_pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_vec = {op_valid, op_a, op_b, overrun, LED, LED_reset, LED_pb};

  function automatic logic [35:0] exp_vec();
    return {m_valid, m_a, m_b, m_ovr, m_db[NCH-1:1], m_ledrst, m_valid};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_d1 = '0; m_d2 = '0; m_db = '0;
    for (int ch = 0; ch < NCH; ch++) begin m_run[ch] = 0; m_last[ch] = 1'b0; end
    m_holding = 0; m_fire = 0; m_waitrel = 0; m_ht = 0;
    m_valid = 0; m_ovr = 0; m_ledrst = 1; m_a = '0; m_b = '0;
  endtask

  // One clock edge of the reference: debounced bit = last NS tick samples all agree and differ
  task automatic model_edge();
    logic tk, fire_now, s;
    if (!reset) return;
    tk = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    m_ledrst = 1'b0;
    fire_now = m_fire;
    m_ovr = 1'b0;
    if (fire_now) begin
      if (!m_valid || op_ready) begin
        m_a = m_db[NCH-1 -: W]; m_b = m_db[W:1]; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && op_ready) begin
      m_valid = 1'b0;
    end
    if (fire_now) begin
      m_fire = 0; m_waitrel = 1;
    end else if (m_waitrel) begin
      if (!m_db[0]) m_waitrel = 0;
    end else if (m_holding) begin
      if (tk) begin
        if (!m_db[0]) m_holding = 0;
        else begin
          m_ht++;
          if (m_ht == HT) begin m_holding = 0; m_fire = 1; end
        end
      end
    end else if (m_db[0]) begin
      m_holding = 1; m_ht = 0;
    end
    if (tk) begin
      for (int ch = 0; ch < NCH; ch++) begin
        s = m_d2[ch];
        if (m_run[ch] > 0 && s == m_last[ch]) m_run[ch]++;
        else begin m_run[ch] = 1; m_last[ch] = s; end
        if (s != m_db[ch] && m_run[ch] >= NS) m_db[ch] = s;
      end
    end
    m_d2 = m_d1;
    m_d1 = {A, B, pb_entrada};
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] ra, rb;
    reset = 1'b1; A = '0; B = '0; pb_entrada = 1'b0; op_ready = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({op_valid, op_a, op_b, overrun, LED, LED_pb} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {op_valid, op_a, op_b, overrun, LED, LED_pb});
    end
    checks++;
    if (LED_reset !== 1'b1) begin errors++; $display("FAIL reset_led: got %b want 1", LED_reset); end
    @(negedge clk);
    ra = 8'h3C ^ 8'($urandom_range(1, 255)); rb = 8'($urandom_range(1, 255));
    if (ra == 0) ra = 8'h11;
    A = ra; B = rb;
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_release cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i < 10) begin
        checks++;
        if (LED !== '0 || LED_reset !== 1'b0) begin
          errors++; $display("FAIL reset_led_early cycle %0d: got LED=%h LED_reset=%b want 0/0", i, LED, LED_reset);
        end
      end
    end
    checks++;
    if (LED !== {ra, rb}) begin errors++; $display("FAIL reset_led_settle: got %h want %h", LED, {ra, rb}); end
  endtask

  task automatic test_debounce();
    A = 8'h00;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL debounce_pre cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    for (int i = 0; i < 40; i++) begin
      A = ((i / 3) % 2 == 1) ? 8'hFF : 8'h00;
      cyc();
      checks++;
      if (dut_vec !== exp_vec() || LED[15:8] !== 8'h00) begin
        errors++; $display("FAIL debounce_glitch cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    A = 8'hA5;
    for (int i = 0; i < 14; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL debounce_settle cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (LED[15:8] !== 8'hA5) begin errors++; $display("FAIL debounce_value: got %h want a5", LED[15:8]); end
  endtask

  task automatic test_short_press();
    pb_entrada = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 4*TD) pb_entrada = 1'b0;
      cyc();
      checks++;
      if (dut_vec !== exp_vec() || op_valid !== 1'b0 || overrun !== 1'b0) begin
        errors++; $display("FAIL short_press cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_held_press();
    int rises;
    logic prev;
    A = 8'hF3; B = 8'h07; op_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL held_settle cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    pb_entrada = 1'b1; rises = 0; prev = op_valid;
    for (int i = 0; i < 20*TD; i++) begin
      cyc();
      if (op_valid && !prev) rises++;
      prev = op_valid;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL held_press cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (rises !== 1 || op_valid !== 1'b1) begin errors++; $display("FAIL held_rises: got %0d/%b want 1/1", rises, op_valid); end
    checks++;
    if (op_a !== 8'hF3 || op_b !== 8'h07) begin errors++; $display("FAIL held_operands: got %h %h want f3 07", op_a, op_b); end
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    checks++;
    if (op_valid !== 1'b0) begin errors++; $display("FAIL held_accept: got op_valid=%b want 0", op_valid); end
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec() || op_valid !== 1'b0) begin
        errors++; $display("FAIL held_no_repeat cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    pb_entrada = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL held_release cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic press(input int hold, input string tag, output int ovr_pulses);
    ovr_pulses = 0;
    pb_entrada = 1'b1;
    for (int i = 0; i < hold + 24; i++) begin
      if (i == hold) pb_entrada = 1'b0;
      cyc();
      if (overrun) ovr_pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL %s cycle %0d: got %h want %h", tag, i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] ra, rb;
    int ov;
    ra = 8'($urandom); rb = 8'($urandom);
    A = ra; B = rb; op_ready = 1'b0;
    repeat (16) cyc();
    press(60, "overrun_first", ov);
    checks++;
    if (op_valid !== 1'b1 || op_a !== ra || op_b !== rb || ov !== 0) begin
      errors++; $display("FAIL overrun_first_load: got %b %h %h ov=%0d want 1 %h %h ov=0", op_valid, op_a, op_b, ov, ra, rb);
    end
    A = ~ra; B = ~rb;
    repeat (16) cyc();
    press(60, "overrun_second", ov);
    checks++;
    if (ov !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d pulses want 1", ov); end
    checks++;
    if (op_valid !== 1'b1 || op_a !== ra || op_b !== rb) begin
      errors++; $display("FAIL overrun_hold: got %b %h %h want 1 %h %h", op_valid, op_a, op_b, ra, rb);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nc, nd;
    logic fired, fire_now;
    int xf;
    nc = ~op_a; nd = 8'($urandom);
    A = nc; B = nd; op_ready = 1'b0;
    repeat (16) cyc();
    checks++;
    if (op_valid !== 1'b1) begin errors++; $display("FAIL b2b_precondition: got op_valid=%b want 1", op_valid); end
    pb_entrada = 1'b1; fired = 1'b0; xf = 0;
    for (int i = 0; i < 80 && !fired; i++) begin
      op_ready = m_fire;
      fire_now = m_fire;
      if (op_valid && op_ready) xf++;
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL b2b cycle %0d: got %h want %h", i, dut_vec, exp_vec()); end
      if (fire_now) fired = 1'b1;
    end
    op_ready = 1'b0;
    checks++;
    if (!fired) begin errors++; $display("FAIL b2b_timeout: got no capture want one within 80 cycles"); end
    checks++;
    if (op_valid !== 1'b1 || overrun !== 1'b0 || op_a !== nc || op_b !== nd || xf !== 1) begin
      errors++; $display("FAIL b2b_result: got v=%b ovr=%b %h %h xf=%0d want 1 0 %h %h 1", op_valid, overrun, op_a, op_b, xf, nc, nd);
    end
    pb_entrada = 1'b0;
    repeat (24) cyc();
  endtask

  task automatic test_random();
    int hold, gap;
    for (int r = 0; r < 6; r++) begin
      A = 8'($urandom); B = 8'($urandom);
      hold = $urandom_range(8, 70); gap = $urandom_range(20, 40);
      for (int i = 0; i < 16 + hold + gap; i++) begin
        pb_entrada = (i >= 16 && i < 16 + hold);
        op_ready = ($urandom_range(0, 3) == 0);
        if (i == 16 + hold / 2) A = 8'($urandom);
        cyc();
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random r%0d cycle %0d: got %h want %h", r, i, dut_vec, exp_vec()); end
      end
    end
    op_ready = 1'b0; pb_entrada = 1'b0;
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    repeat (16) cyc();
    pb_entrada = 1'b1;
    for (int i = 0; i < 80 && !m_valid; i++) cyc();
    checks++;
    if (op_valid !== 1'b1 || !m_valid) begin errors++; $display("FAIL reset_mid_pending: got op_valid=%b want 1", op_valid); end
    #2 reset = 1'b0; pb_entrada = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({op_valid, op_a, op_b, overrun, LED, LED_pb} !== '0 || LED_reset !== 1'b1) begin
      errors++; $display("FAIL reset_mid_async: got %h want 2", dut_vec);
    end
    @(negedge clk);
    repeat (3) cyc();
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_mid_held: got %h want %h", dut_vec, exp_vec()); end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if (dut_vec !== exp_vec() || op_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_after cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_short_press();
    test_held_press();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
